// File: rtl/fcov_seq_pkg.sv
// Shared definitions for the RVVI retire sequencer.
//   seq_state_e    : sequencer FSM states (IDLE, ISSUE)
//   SAMPLE_CNT_W   : width of the issued-sample statistics counter
//   DROP_CNT_W     : width of the dropped-group statistics counter
//   first_pending(): rotated first-set-bit search over a retire mask
// Port summary: none (package).
package fcov_seq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;

    localparam int SAMPLE_CNT_W   = 32;
    localparam int DROP_CNT_W     = 16;

    // Upper bounds for the search helper; a sequencer instance must keep
    // NHART <= SEQ_MAX_HART and RETIRE <= SEQ_MAX_RETIRE.
    localparam int SEQ_MAX_HART   = 8;
    localparam int SEQ_MAX_RETIRE = 8;
    localparam int SEQ_MAX_SLOTS  = SEQ_MAX_HART * SEQ_MAX_RETIRE;
    localparam int SEQ_IDX_W      = $clog2(SEQ_MAX_SLOTS);

    // Returns the flat index (h*retire+s) of the first pending bit when harts
    // are visited from start_hart upward (wrapping at nhart) and slots in
    // ascending order within a hart; -1 when the mask is empty. The scan runs
    // from the last position back to the first so the final hit wins, which
    // keeps the loop free of early exits.
    function automatic int first_pending(
        input logic [SEQ_MAX_SLOTS-1:0] mask,
        input int                       start_hart,
        input int                       nhart,
        input int                       retire
    );
        int                   result;
        int                   h;
        logic [SEQ_IDX_W-1:0] idx;
        result = -1;
        for (int ho = SEQ_MAX_HART - 1; ho >= 0; ho--) begin
            for (int s = SEQ_MAX_RETIRE - 1; s >= 0; s--) begin
                if (ho < nhart && s < retire) begin
                    h = start_hart + ho;
                    if (h >= nhart) begin
                        h = h - nhart;
                    end
                    idx = SEQ_IDX_W'(h * retire + s);
                    if (mask[idx]) begin
                        result = h * retire + s;
                    end
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rvvi_retire_sequencer_if.sv
// Bundle between the RVVI trace side, the coverage sampler and the sequencer.
//   in_valid/in_trap [NSLOT]      per-slot retire valid and trap, index h*RETIRE+s
//   in_insn [NSLOT*ILEN]          per-slot instruction
//   in_pc   [NSLOT*XLEN]          per-slot pc_rdata
//   sample_valid/sample_ready     sample handshake
//   sample_hart/slot/insn/pc/trap presented sample
//   overflow, sample_count, drop_count   status and statistics
//   seq_state                     sequencer FSM state (debug)
// Modports: master = trace source + sample consumer, slave = sequencer.
//
// Handshake: a sample transfers on a clock edge where sample_valid and
// sample_ready are both high. While sample_valid is high and sample_ready is
// low, every sample_* field stays constant. sample_valid never depends on
// sample_ready. The trace side has no back-pressure: a set in_valid bit is a
// retirement that happened in that cycle.
interface rvvi_retire_sequencer_if #(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int NHART  = 1,
    parameter int RETIRE = 1
) ();
    import fcov_seq_pkg::*;

    localparam int NSLOT = NHART * RETIRE;
    localparam int HW    = $clog2(NHART) + 1;
    localparam int SW    = $clog2(RETIRE) + 1;

    logic [NSLOT-1:0]        in_valid;
    logic [NSLOT-1:0]        in_trap;
    logic [NSLOT*ILEN-1:0]   in_insn;
    logic [NSLOT*XLEN-1:0]   in_pc;

    logic                    sample_valid;
    logic                    sample_ready;
    logic [HW-1:0]           sample_hart;
    logic [SW-1:0]           sample_slot;
    logic [ILEN-1:0]         sample_insn;
    logic [XLEN-1:0]         sample_pc;
    logic                    sample_trap;

    logic                    overflow;
    logic [SAMPLE_CNT_W-1:0] sample_count;
    logic [DROP_CNT_W-1:0]   drop_count;
    seq_state_e              seq_state;

    modport master (
        output in_valid, in_trap, in_insn, in_pc, sample_ready,
        input  sample_valid, sample_hart, sample_slot, sample_insn, sample_pc,
               sample_trap, overflow, sample_count, drop_count, seq_state
    );

    modport slave (
        input  in_valid, in_trap, in_insn, in_pc, sample_ready,
        output sample_valid, sample_hart, sample_slot, sample_insn, sample_pc,
               sample_trap, overflow, sample_count, drop_count, seq_state
    );

endinterface

// File: rtl/rvvi_group_fifo.sv
// Registered FIFO holding whole retire groups.
//   clk, reset  clock, asynchronous active-high reset (empties the FIFO)
//   push, din   write request and data; ignored when full unless pop is
//               accepted in the same cycle
//   pop, dout   read request and head entry (dout is valid while !empty)
//   full, empty occupancy flags
// DEPTH must be a power of two and at least 2.
module rvvi_group_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// Serialises retired instructions from every RVVI hart/retire slot into one
// ordered stream for the coverage sampler, one sample per cycle.
//   clk     trace clock
//   reset   asynchronous, active-high
//   bus     rvvi_retire_sequencer_if.slave: trace inputs, sample handshake,
//           overflow, statistics counters and FSM state
// Each cycle with any in_valid bit set pushes the whole group into a
// GDEPTH-entry FIFO; a group arriving while the FIFO is full (and nothing is
// popped that cycle) is dropped and sets the sticky overflow flag. The FSM
// loads one group at a time into a working register and issues its pending
// slots starting at a round-robin hart, slots ascending within each hart.
// Build option: FCOV_SEQ_STATS_EN enables sample_count / drop_count; when it
// is not defined both ports read 0 and no counters are built.
module rvvi_retire_sequencer
    import fcov_seq_pkg::*;
#(
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int NHART  = 1,
    parameter int RETIRE = 1,
    parameter int GDEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    rvvi_retire_sequencer_if.slave  bus
);
    localparam int NSLOT = NHART * RETIRE;
    localparam int HW    = $clog2(NHART) + 1;
    localparam int SW    = $clog2(RETIRE) + 1;
    localparam int HPW   = (NHART > 1) ? $clog2(NHART) : 1;
    localparam int GW    = NSLOT * (2 + ILEN + XLEN);

    // ------------------------------------------------------------------
    // Group capture
    // ------------------------------------------------------------------
    logic [GW-1:0]         grp_in;
    logic [GW-1:0]         grp_out;
    logic                  grp_push;
    logic                  grp_drop;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [NSLOT-1:0]      head_valid;
    logic [NSLOT-1:0]      head_trap;
    logic [NSLOT*ILEN-1:0] head_insn;
    logic [NSLOT*XLEN-1:0] head_pc;

    assign grp_in   = {bus.in_pc, bus.in_insn, bus.in_trap, bus.in_valid};
    assign grp_push = |bus.in_valid;
    assign grp_drop = grp_push && fifo_full && !fifo_pop;

    rvvi_group_fifo #(
        .W     (GW),
        .DEPTH (GDEPTH)
    ) u_group_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grp_push),
        .pop   (fifo_pop),
        .din   (grp_in),
        .dout  (grp_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_pc, head_insn, head_trap, head_valid} = grp_out;

    // ------------------------------------------------------------------
    // Working group and pending-slot selection
    // ------------------------------------------------------------------
    seq_state_e            state_q;
    seq_state_e            state_d;
    logic [NSLOT-1:0]      work_mask;
    logic [NSLOT-1:0]      work_trap;
    logic [NSLOT*ILEN-1:0] work_insn;
    logic [NSLOT*XLEN-1:0] work_pc;
    logic [HPW-1:0]        start_hart;
    logic [HPW-1:0]        rr_ptr;
    logic                  overflow_q;
    logic                  load_grp;
    logic                  fire;

    logic [SEQ_MAX_SLOTS-1:0] mask_ext;
    int                       cur_idx;
    logic [NSLOT-1:0]         cur_onehot;
    logic [NSLOT-1:0]         mask_left;

    always_comb begin
        mask_ext = '0;
        mask_ext[NSLOT-1:0] = work_mask;
        cur_idx = first_pending(mask_ext, int'(start_hart), NHART, RETIRE);
    end

    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < NSLOT; i++) begin
            cur_onehot[i] = (cur_idx == i);
        end
    end

    // Bits still pending once the presented slot is accepted.
    assign mask_left = work_mask & ~cur_onehot;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load_grp = 1'b0;
        fire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load_grp = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sample_ready) begin
                    fire = 1'b1;
                    if (mask_left == '0) begin
                        // Chain straight into the next group so back-to-back
                        // groups issue without a bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            load_grp = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Working register, round-robin pointer, sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_mask  <= '0;
            work_trap  <= '0;
            work_insn  <= '0;
            work_pc    <= '0;
            start_hart <= '0;
            rr_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (load_grp) begin
                work_mask  <= head_valid;
                work_trap  <= head_trap;
                work_insn  <= head_insn;
                work_pc    <= head_pc;
                start_hart <= rr_ptr;
                if (rr_ptr == HPW'(NHART - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= rr_ptr + 1'b1;
                end
            end else if (fire) begin
                work_mask <= mask_left;
            end
            if (grp_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample outputs. With no pending bit the one-hot is all zero, so the
    // payload reads 0 whenever sample_valid is low.
    // ------------------------------------------------------------------
    logic [HW-1:0]   hart_c;
    logic [SW-1:0]   slot_c;
    logic            trap_c;
    logic [ILEN-1:0] insn_c;
    logic [XLEN-1:0] pc_c;

    always_comb begin
        hart_c = '0;
        slot_c = '0;
        trap_c = 1'b0;
        insn_c = '0;
        pc_c   = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (cur_onehot[i]) begin
                hart_c = HW'(i / RETIRE);
                slot_c = SW'(i % RETIRE);
                trap_c = work_trap[i];
                insn_c = work_insn[i*ILEN +: ILEN];
                pc_c   = work_pc[i*XLEN +: XLEN];
            end
        end
    end

    assign bus.sample_valid = (state_q == ISSUE);
    assign bus.sample_hart  = hart_c;
    assign bus.sample_slot  = slot_c;
    assign bus.sample_trap  = trap_c;
    assign bus.sample_insn  = insn_c;
    assign bus.sample_pc    = pc_c;
    assign bus.overflow     = overflow_q;
    assign bus.seq_state    = state_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef FCOV_SEQ_STATS_EN
    logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (fire) begin
                sample_cnt_q <= sample_cnt_q + 1'b1;
            end
            // Drop counter saturates instead of wrapping.
            if (grp_drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign bus.sample_count = sample_cnt_q;
    assign bus.drop_count   = drop_cnt_q;
`else
    assign bus.sample_count = '0;
    assign bus.drop_count   = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Directed bench for rvvi_retire_sequencer. Two instances: a 1-hart/1-slot
// build for the basic latency case and a 2-hart/2-slot build for ordering,
// back-pressure, overflow and reset cases. Expected samples are queued in
// exp_q in hand-derived issue order.
module tb_rvvi_retire_sequencer;
    import fcov_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rvvi_retire_sequencer_if #(.ILEN(32), .XLEN(64), .NHART(1), .RETIRE(1)) if1 ();
    rvvi_retire_sequencer_if #(.ILEN(32), .XLEN(64), .NHART(2), .RETIRE(2)) if2 ();

    rvvi_retire_sequencer #(
        .ILEN(32), .XLEN(64), .NHART(1), .RETIRE(1), .GDEPTH(4)
    ) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (if1)
    );

    rvvi_retire_sequencer #(
        .ILEN(32), .XLEN(64), .NHART(2), .RETIRE(2), .GDEPTH(4)
    ) u_dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (if2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // {hart[3:0], slot[3:0], trap, insn[31:0], pc[63:0]}
    localparam int EW = 4 + 4 + 1 + 32 + 64;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] g_insn(input int g, input int i);
        return 32'h1000_0000 + 32'(g * 16 + i);
    endfunction

    function automatic logic [63:0] g_pc(input int g, input int i);
        return 64'h8000_0000 + 64'(g * 256 + i * 4);
    endfunction

    task automatic drive_group2(input int g, input logic [3:0] mask, input logic [3:0] trap);
        if2.in_valid = mask;
        if2.in_trap  = trap;
        for (int i = 0; i < 4; i++) begin
            if2.in_insn[i*32 +: 32] = g_insn(g, i);
            if2.in_pc[i*64 +: 64]   = g_pc(g, i);
        end
    endtask

    task automatic idle2();
        if2.in_valid = '0;
        if2.in_trap  = '0;
    endtask

    task automatic expect2(input int g, input int idx, input logic [3:0] trap);
        logic [1:0] b;
        b = 2'(idx);
        exp_q.push_back({4'(idx / 2), 4'(idx % 2), trap[b], g_insn(g, idx), g_pc(g, idx)});
    endtask

    task automatic check_sample(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_sample"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hart"}, 64'(if2.sample_hart), 64'(e[104:101]));
            check({tag, "_slot"}, 64'(if2.sample_slot), 64'(e[100:97]));
            check({tag, "_trap"}, 64'(if2.sample_trap), 64'(e[96]));
            check({tag, "_insn"}, 64'(if2.sample_insn), 64'(e[95:64]));
            check({tag, "_pc"},   if2.sample_pc,        e[63:0]);
        end
    endtask

    // Consumes up to n samples from the 2x2 instance within budget cycles;
    // span is the number of cycles from the first to the last sample.
    task automatic drain(input string tag, input int n, input int budget,
                         output int got, output int span);
        int first;
        first = -1;
        got   = 0;
        span  = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (if2.sample_valid && if2.sample_ready) begin
                if (first < 0) first = c;
                check_sample(tag);
                got++;
                span = c - first + 1;
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         got;
        int         span;
        logic [3:0] m;

        rst              = 1'b1;
        if1.in_valid     = '0;
        if1.in_trap      = '0;
        if1.in_insn      = '0;
        if1.in_pc        = '0;
        if1.sample_ready = 1'b0;
        if2.in_insn      = '0;
        if2.in_pc        = '0;
        if2.sample_ready = 1'b0;
        idle2();
        step();
        step();

        // Reset state
        check("rst_valid1",    64'(if1.sample_valid), 64'd0);
        check("rst_valid2",    64'(if2.sample_valid), 64'd0);
        check("rst_overflow2", 64'(if2.overflow),     64'd0);
        check("rst_pc2",       if2.sample_pc,         64'd0);
        check("rst_hart2",     64'(if2.sample_hart),  64'd0);
        check("rst_state2",    64'(if2.seq_state),    64'(IDLE));
        check("rst_scount2",   64'(if2.sample_count), 64'd0);
        check("rst_dcount2",   64'(if2.drop_count),   64'd0);
        rst = 1'b0;
        step();
        step();

        // T1: single hart/slot, first sample two cycles after capture
        if1.sample_ready = 1'b1;
        if1.in_valid     = 1'b1;
        if1.in_trap      = 1'b0;
        if1.in_pc        = 64'h0000_0000_8000_0000;
        if1.in_insn      = 32'h0000_0013;
        step();
        if1.in_valid = 1'b0;
        check("t1_valid_n1", 64'(if1.sample_valid), 64'd0);
        step();
        check("t1_valid_n2", 64'(if1.sample_valid), 64'd1);
        check("t1_hart",     64'(if1.sample_hart),  64'd0);
        check("t1_slot",     64'(if1.sample_slot),  64'd0);
        check("t1_pc",       if1.sample_pc,         64'h0000_0000_8000_0000);
        check("t1_insn",     64'(if1.sample_insn),  64'h13);
        check("t1_trap",     64'(if1.sample_trap),  64'd0);
        step();
        check("t1_valid_after", 64'(if1.sample_valid), 64'd0);

        // T2: two full groups, start hart alternates, no bubble
        if2.sample_ready = 1'b1;
        drive_group2(0, 4'b1111, 4'b0101);
        expect2(0, 0, 4'b0101);
        expect2(0, 1, 4'b0101);
        expect2(0, 2, 4'b0101);
        expect2(0, 3, 4'b0101);
        step();
        drive_group2(1, 4'b1111, 4'b0000);
        expect2(1, 2, 4'b0000);
        expect2(1, 3, 4'b0000);
        expect2(1, 0, 4'b0000);
        expect2(1, 1, 4'b0000);
        step();
        idle2();
        drain("t2", 8, 20, got, span);
        check("t2_count",     64'(got), 64'd8);
        check("t2_no_bubble", 64'(span), 64'd8);
        check("t2_valid_after", 64'(if2.sample_valid), 64'd0);
`ifdef FCOV_SEQ_STATS_EN
        check("t2_sample_count", 64'(if2.sample_count), 64'd8);
`else
        check("t2_sample_count_tied", 64'(if2.sample_count), 64'd0);
`endif

        // T3: back-pressure holds the presented sample (start hart 0 again)
        if2.sample_ready = 1'b0;
        drive_group2(2, 4'b0110, 4'b0100);
        step();
        idle2();
        step();
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_valid", 64'(if2.sample_valid), 64'd1);
            check("t3_hold_hart",  64'(if2.sample_hart),  64'd0);
            check("t3_hold_slot",  64'(if2.sample_slot),  64'd1);
            check("t3_hold_trap",  64'(if2.sample_trap),  64'd0);
            check("t3_hold_insn",  64'(if2.sample_insn),  64'(g_insn(2, 1)));
            check("t3_hold_pc",    if2.sample_pc,         g_pc(2, 1));
            step();
        end
        if2.sample_ready = 1'b1;
        expect2(2, 1, 4'b0100);
        expect2(2, 2, 4'b0100);
        drain("t3", 2, 10, got, span);
        check("t3_count", 64'(got), 64'd2);

        // T5: FIFO full, last bit accepted as a new group arrives -> no drop
        if2.sample_ready = 1'b0;
        for (int g = 10; g < 15; g++) begin
            drive_group2(g, 4'b0001, 4'b0000);
            expect2(g, 0, 4'b0000);
            step();
        end
        idle2();
        check("t5_pre_overflow", 64'(if2.overflow), 64'd0);
        check("t5_pre_valid",    64'(if2.sample_valid), 64'd1);
        drive_group2(15, 4'b1000, 4'b1000);
        expect2(15, 3, 4'b1000);
        if2.sample_ready = 1'b1;
        check_sample("t5_first");
        step();
        idle2();
        drain("t5", 5, 20, got, span);
        check("t5_count",    64'(got), 64'd5);
        check("t5_overflow", 64'(if2.overflow), 64'd0);
`ifdef FCOV_SEQ_STATS_EN
        check("t5_drop_count",   64'(if2.drop_count),   64'd0);
        check("t5_sample_count", 64'(if2.sample_count), 64'd16);
`endif

        // T4: 7 groups with the consumer stalled -> 5 kept, 2 dropped
        if2.sample_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            m = 4'b0001 << (k % 4);
            drive_group2(20 + k, m, 4'b0000);
            if (k < 5) expect2(20 + k, k % 4, 4'b0000);
            step();
        end
        idle2();
        step();
        check("t4_overflow", 64'(if2.overflow), 64'd1);
`ifdef FCOV_SEQ_STATS_EN
        check("t4_drop_count", 64'(if2.drop_count), 64'd2);
`else
        check("t4_drop_count_tied", 64'(if2.drop_count), 64'd0);
`endif
        if2.sample_ready = 1'b1;
        drain("t4", 5, 20, got, span);
        check("t4_count",       64'(got), 64'd5);
        check("t4_valid_after", 64'(if2.sample_valid), 64'd0);
        check("t4_q_empty",     64'(exp_q.size()), 64'd0);
`ifdef FCOV_SEQ_STATS_EN
        check("t4_sample_count", 64'(if2.sample_count), 64'd21);
`endif

        // T6: reset during ISSUE, then hart order restarts at hart 0
        if2.sample_ready = 1'b0;
        drive_group2(30, 4'b1111, 4'b0000);
        step();
        idle2();
        step();
        check("t6_pre_valid", 64'(if2.sample_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid",    64'(if2.sample_valid), 64'd0);
        check("t6_rst_overflow", 64'(if2.overflow),     64'd0);
        check("t6_rst_state",    64'(if2.seq_state),    64'(IDLE));
        check("t6_rst_scount",   64'(if2.sample_count), 64'd0);
        #2;
        rst = 1'b0;
        step();
        if2.sample_ready = 1'b1;
        drive_group2(31, 4'b1111, 4'b1000);
        expect2(31, 0, 4'b1000);
        expect2(31, 1, 4'b1000);
        expect2(31, 2, 4'b1000);
        expect2(31, 3, 4'b1000);
        step();
        idle2();
        check("t6_valid_n1", 64'(if2.sample_valid), 64'd0);
        step();
        check("t6_valid_n2", 64'(if2.sample_valid), 64'd1);
        drain("t6", 4, 10, got, span);
        check("t6_count",     64'(got),  64'd4);
        check("t6_no_bubble", 64'(span), 64'd4);
        check("t6_q_empty",   64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
